// File: rtl/controladora_multicanal_pkg.sv
// Shared types and default parameter values for the multi-channel lamp controller.
// estado_t is encoded so that bit 1 means MANUAL mode and bit 0 means lamp on.
// led and saida are decoded directly from those two bits.
package controladora_pkg;

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'b00,
        AUTO_ON    = 2'b01,
        MANUAL_OFF = 2'b10,
        MANUAL_ON  = 2'b11
    } estado_t;

    localparam int N_CH_DEF              = 4;
    localparam int DEBOUNCE_P_DEF        = 300;
    localparam int SWITCH_MODE_MIN_T_DEF = 5300;
    localparam int AUTO_SHUTDOWN_T_DEF   = 30000;

    function automatic logic is_manual(input estado_t e);
        return e[1];
    endfunction

    function automatic logic is_on(input estado_t e);
        return e[0];
    endfunction

endpackage

// File: rtl/controladora_multicanal_debounce.sv
// Button debouncer for one channel.
//   clk, rst : clock and synchronous active-high reset
//   raw      : raw button level (assumed already synchronous to clk)
//   level    : debounced level
//   rise     : one-cycle strobe, high in the first cycle level reads 1
//   fall     : one-cycle strobe, high in the first cycle level reads 0
module debounce
    import controladora_pkg::*;
#(
    parameter int DEBOUNCE_P = DEBOUNCE_P_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_P + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // The counter tracks how many consecutive cycles raw has disagreed with
    // the accepted level; the level flips on the DEBOUNCE_P-th such cycle.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (raw != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_P - 1)) begin
                level_d = raw;
                rise_d  = raw;
                fall_d  = ~raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/controladora_multicanal.sv
// Multi-channel lamp controller. Each channel has an AUTO mode (lamp driven by a
// presence sensor with an inactivity timeout) and a MANUAL mode (lamp toggled by
// short button presses). A long press swaps modes.
//   clk, rst       : clock and synchronous active-high reset
//   push_button    : raw button per channel
//   infravermelho  : presence sensor per channel
//   desligar_todos : global off, level-sensitive
//   led            : 1 = channel in MANUAL mode
//   saida          : lamp drive per channel
//   qtd_acesas     : registered count of lit channels
module controladora_multicanal
    import controladora_pkg::*;
#(
    parameter int N_CH              = N_CH_DEF,
    parameter int DEBOUNCE_P        = DEBOUNCE_P_DEF,
    parameter int SWITCH_MODE_MIN_T = SWITCH_MODE_MIN_T_DEF,
    parameter int AUTO_SHUTDOWN_T   = AUTO_SHUTDOWN_T_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             push_button,
    input  logic [N_CH-1:0]             infravermelho,
    input  logic                        desligar_todos,
    output logic [N_CH-1:0]             led,
    output logic [N_CH-1:0]             saida,
    output logic [$clog2(N_CH+1)-1:0]   qtd_acesas
);

    localparam int PRESS_W = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int SHUT_W  = $clog2(AUTO_SHUTDOWN_T + 1);
    localparam int QTD_W   = $clog2(N_CH + 1);

    logic [N_CH-1:0]    db_level, db_rise, db_fall;
    logic [N_CH-1:0]    long_press, short_press;
    logic [N_CH-1:0]    ir_q, ir_d;
    estado_t            estado_q [N_CH];
    estado_t            estado_d [N_CH];
    logic [PRESS_W-1:0] press_q  [N_CH];
    logic [PRESS_W-1:0] press_d  [N_CH];
    logic [SHUT_W-1:0]  shut_q   [N_CH];
    logic [SHUT_W-1:0]  shut_d   [N_CH];
    logic [QTD_W-1:0]   qtd_q, qtd_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_db
        debounce #(.DEBOUNCE_P(DEBOUNCE_P)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (push_button[g]),
            .level (db_level[g]),
            .rise  (db_rise[g]),
            .fall  (db_fall[g])
        );
    end

    // The global off also blanks the presence register so a sensor pulse
    // arriving together with it cannot relight a lamp on the next cycle.
    assign ir_d = desligar_todos ? '0 : infravermelho;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // Press length includes the rising-edge cycle and saturates.
            press_d[i] = press_q[i];
            if (db_rise[i]) begin
                press_d[i] = PRESS_W'(1);
            end else if (db_level[i] && (press_q[i] < PRESS_W'(SWITCH_MODE_MIN_T))) begin
                press_d[i] = press_q[i] + 1'b1;
            end

            long_press[i]  = db_fall[i] && (press_q[i] >= PRESS_W'(SWITCH_MODE_MIN_T));
            short_press[i] = db_fall[i] && !(press_q[i] >= PRESS_W'(SWITCH_MODE_MIN_T));

            estado_d[i] = estado_q[i];
            shut_d[i]   = '0;
            if (long_press[i]) begin
                estado_d[i] = is_manual(estado_q[i]) ? AUTO_OFF : MANUAL_OFF;
            end else if (desligar_todos) begin
                estado_d[i] = is_manual(estado_q[i]) ? MANUAL_OFF : AUTO_OFF;
            end else begin
                case (estado_q[i])
                    AUTO_OFF: begin
                        if (ir_q[i]) estado_d[i] = AUTO_ON;
                    end
                    AUTO_ON: begin
                        if (ir_q[i]) begin
                            shut_d[i] = '0;
                        end else if (shut_q[i] == SHUT_W'(AUTO_SHUTDOWN_T - 1)) begin
                            estado_d[i] = AUTO_OFF;
                        end else begin
                            shut_d[i] = shut_q[i] + 1'b1;
                        end
                    end
                    MANUAL_OFF: begin
                        if (short_press[i]) estado_d[i] = MANUAL_ON;
                    end
                    MANUAL_ON: begin
                        if (short_press[i]) estado_d[i] = MANUAL_OFF;
                    end
                    default: estado_d[i] = AUTO_OFF;
                endcase
            end
        end
    end

    always_comb begin
        qtd_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            led[i]   = is_manual(estado_q[i]);
            saida[i] = is_on(estado_q[i]);
            qtd_d    = qtd_d + QTD_W'(saida[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                estado_q[i] <= AUTO_OFF;
                press_q[i]  <= '0;
                shut_q[i]   <= '0;
            end
            ir_q  <= '0;
            qtd_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                estado_q[i] <= estado_d[i];
                press_q[i]  <= press_d[i];
                shut_q[i]   <= shut_d[i];
            end
            ir_q  <= ir_d;
            qtd_q <= qtd_d;
        end
    end

    assign qtd_acesas = qtd_q;

endmodule
